// File: rtl/db_access_sched.sv
// Sequencer/arbiter for the data-bank router: shares the bank between a host port
// (write, read, clear-all) and the ALU writeback port, decoding router selects from state.
module db_access_sched #(
  parameter int ADDRW    = 5,
  parameter int MAX_WAIT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             HOST_REQ,
  input  logic [1:0]       HOST_OP,
  input  logic [ADDRW-1:0] HOST_ADDR,
  output logic             HOST_ACK,
  input  logic             ALU_REQ,
  input  logic             WRITE_REQ,
  input  logic             READY,
  output logic             ALU_DONE,
  output logic             ALU_ERR,
  output logic             BUSY,
  output logic [1:0]       sel_data,
  output logic             sel_dira,
  output logic             sel_dirb,
  output logic [1:0]       sel_write,
  output logic [ADDRW-1:0] DIR_EXT,
  output logic [2:0]       dbg_state
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_H_WR     = 3'd1,
    S_H_RD     = 3'd2,
    S_H_RD_ACK = 3'd3,
    S_CLR      = 3'd4,
    S_ALU_RUN  = 3'd5
  } state_t;

  localparam logic GRANT_HOST = 1'b0;
  localparam logic GRANT_ALU  = 1'b1;

  state_t           state, state_nx;
  logic [ADDRW-1:0] clr_cnt, clr_nx;
  logic [WW-1:0]    wait_cnt, wait_nx;
  logic             last_grant, last_nx;
  logic             ack_c, done_c, err_c;
  logic             host_win, alu_win;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      wait_cnt   <= '0;
      last_grant <= GRANT_ALU;
    end else begin
      state      <= state_nx;
      clr_cnt    <= clr_nx;
      wait_cnt   <= wait_nx;
      last_grant <= last_nx;
    end
  end

  // On a tie the side that did not win last time gets the grant.
  assign host_win = HOST_REQ & (~ALU_REQ | (last_grant == GRANT_ALU));
  assign alu_win  = ALU_REQ & (~HOST_REQ | (last_grant == GRANT_HOST));

  always_comb begin
    state_nx = state;
    clr_nx   = clr_cnt;
    wait_nx  = wait_cnt;
    last_nx  = last_grant;
    ack_c    = 1'b0;
    done_c   = 1'b0;
    err_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (host_win) begin
          last_nx = GRANT_HOST;
          case (HOST_OP)
            2'b00:   state_nx = S_H_WR;
            2'b01:   state_nx = S_H_RD;
            2'b10:   state_nx = S_CLR;
            default: ack_c    = 1'b1;
          endcase
        end else if (alu_win) begin
          last_nx  = GRANT_ALU;
          wait_nx  = '0;
          state_nx = S_ALU_RUN;
        end
      end
      S_H_WR: begin
        ack_c    = 1'b1;
        state_nx = S_IDLE;
      end
      S_H_RD: state_nx = S_H_RD_ACK;
      S_H_RD_ACK: begin
        ack_c    = 1'b1;
        state_nx = S_IDLE;
      end
      S_CLR: begin
        if (clr_cnt == {ADDRW{1'b1}}) begin
          ack_c    = 1'b1;
          clr_nx   = '0;
          state_nx = S_IDLE;
        end else begin
          clr_nx = clr_cnt + ADDRW'(1);
        end
      end
      S_ALU_RUN: begin
        // A handshake on the final allowed cycle still counts as success.
        if (WRITE_REQ & READY) begin
          done_c   = 1'b1;
          wait_nx  = '0;
          state_nx = S_IDLE;
        end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
          err_c    = 1'b1;
          wait_nx  = '0;
          state_nx = S_IDLE;
        end else begin
          wait_nx = wait_cnt + WW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    sel_data  = 2'd0;
    sel_dira  = 1'b0;
    sel_dirb  = 1'b0;
    sel_write = 2'd2;
    case (state)
      S_H_WR:     begin sel_dira = 1'b1; sel_write = 2'd3; end
      S_H_RD:     sel_dirb = 1'b1;
      S_H_RD_ACK: sel_dirb = 1'b1;
      S_CLR:      begin sel_data = 2'd2; sel_dira = 1'b1; sel_write = 2'd3; end
      S_ALU_RUN:  begin sel_data = 2'd1; sel_write = 2'd1; end
      default:    ;
    endcase
  end

  assign DIR_EXT   = (state == S_CLR) ? clr_cnt : HOST_ADDR;
  assign BUSY      = (state != S_IDLE);
  assign HOST_ACK  = ack_c & ~RST;
  assign ALU_DONE  = done_c & ~RST;
  assign ALU_ERR   = err_c & ~RST;
  assign dbg_state = state;

endmodule

// File: tb/tb_db_access_sched.sv
// Bench for db_access_sched: per-cycle expected outputs queued by drivers, plus a
// bank/router model that tracks what the selects actually write.
module tb_db_access_sched;

  localparam int ADDRW    = 5;
  localparam int MAX_WAIT = 64;
  localparam int DEPTH    = 1 << ADDRW;
  localparam int VW       = 15;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             HOST_REQ = 1'b0;
  logic [1:0]       HOST_OP = 2'b11;
  logic [ADDRW-1:0] HOST_ADDR = '0;
  logic             HOST_ACK;
  logic             ALU_REQ = 1'b0;
  logic             WRITE_REQ = 1'b0;
  logic             READY = 1'b0;
  logic             ALU_DONE, ALU_ERR, BUSY;
  logic [1:0]       sel_data, sel_write;
  logic             sel_dira, sel_dirb;
  logic [ADDRW-1:0] DIR_EXT;
  logic [2:0]       dbg_state;

  db_access_sched #(.ADDRW(ADDRW), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST), .HOST_REQ(HOST_REQ), .HOST_OP(HOST_OP), .HOST_ADDR(HOST_ADDR),
    .HOST_ACK(HOST_ACK), .ALU_REQ(ALU_REQ), .WRITE_REQ(WRITE_REQ), .READY(READY),
    .ALU_DONE(ALU_DONE), .ALU_ERR(ALU_ERR), .BUSY(BUSY), .sel_data(sel_data),
    .sel_dira(sel_dira), .sel_dirb(sel_dirb), .sel_write(sel_write), .DIR_EXT(DIR_EXT),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // router + bank model
  logic [7:0]       bank [DEPTH];
  logic [7:0]       data_in = 8'h00;
  logic [7:0]       result = 8'h00;
  logic [ADDRW-1:0] ctl_a = 5'h03;
  logic [ADDRW-1:0] ctl_b = 5'h04;
  int               wr_count = 0;
  logic [7:0]       rd_capture = 8'h00;
  logic             we;
  logic [ADDRW-1:0] waddr;
  logic [7:0]       wdata;

  always_comb begin
    case (sel_write)
      2'd0:    we = WRITE_REQ;
      2'd1:    we = WRITE_REQ & READY;
      2'd3:    we = 1'b1;
      default: we = 1'b0;
    endcase
    waddr = sel_dira ? DIR_EXT : ctl_a;
    case (sel_data)
      2'd0:    wdata = data_in;
      2'd1:    wdata = result;
      default: wdata = 8'h00;
    endcase
  end

  always @(posedge CLK) begin
    if (we) begin
      bank[waddr] <= wdata;
      wr_count    <= wr_count + 1;
    end
  end

  // scoreboard: one expected output vector per cycle
  logic [VW-1:0] exp_q[$];

  function automatic logic [VW-1:0] mk(input logic ack, input logic done, input logic err,
                                       input logic [1:0] sd, input logic sa, input logic sb,
                                       input logic [1:0] sw, input logic [ADDRW-1:0] dir,
                                       input logic busy);
    return {ack, done, err, sd, sa, sb, sw, dir, busy};
  endfunction

  always @(negedge CLK) begin
    if (HOST_ACK && sel_dirb) rd_capture = bank[sel_dirb ? DIR_EXT : ctl_b];
    if (exp_q.size() > 0) begin
      logic [VW-1:0] e;
      e = exp_q.pop_front();
      check("outputs", {HOST_ACK, ALU_DONE, ALU_ERR, sel_data, sel_dira, sel_dirb, sel_write,
                        DIR_EXT, BUSY}, e);
    end
  end

  // driver tasks
  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge CLK);
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic host_op(input logic [1:0] op, input logic [ADDRW-1:0] addr);
    HOST_ADDR = addr;
    HOST_OP   = op;
    HOST_REQ  = 1'b1;
    exp_q.push_back(mk(op == 2'b11, 0, 0, 2'd0, 0, 0, 2'd2, addr, 0));
    case (op)
      2'b00: exp_q.push_back(mk(1, 0, 0, 2'd0, 1, 0, 2'd3, addr, 1));
      2'b01: begin
        exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 1, 2'd2, addr, 1));
        exp_q.push_back(mk(1, 0, 0, 2'd0, 0, 1, 2'd2, addr, 1));
      end
      2'b10:
        for (int i = 0; i < DEPTH; i++)
          exp_q.push_back(mk(i == DEPTH - 1, 0, 0, 2'd2, 1, 0, 2'd3, ADDRW'(i), 1));
      default: ;
    endcase
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 0, 2'd2, addr, 0));
    @(posedge CLK);
    #1;
    HOST_REQ = 1'b0;
    drain();
  endtask

  // ready_at < 0: never hand-shake, expect timeout
  task automatic alu_op(input int ready_at);
    int last;
    last = (ready_at >= 0) ? ready_at : MAX_WAIT - 1;
    ALU_REQ = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 0, 2'd2, HOST_ADDR, 0));
    for (int k = 0; k <= last; k++)
      exp_q.push_back(mk(0, (k == ready_at), (ready_at < 0) && (k == last), 2'd1, 0, 0, 2'd1,
                         HOST_ADDR, 1));
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 0, 2'd2, HOST_ADDR, 0));
    @(posedge CLK);
    #1;
    ALU_REQ = 1'b0;
    for (int k = 0; k <= last; k++) begin
      READY     = (k == ready_at);
      WRITE_REQ = (k == ready_at) || (k % 3 == 1);
      @(posedge CLK);
      #1;
    end
    READY     = 1'b0;
    WRITE_REQ = 1'b0;
    drain();
  endtask

  initial begin
    int wc;
    int nz;
    logic [7:0] a_before;
    logic [ADDRW-1:0] ra;
    logic [7:0] rv;

    // reset held 2 cycles
    RST = 1'b1;
    HOST_ADDR = 5'h0b;
    repeat (2) @(negedge CLK);
    check("reset_outputs", {HOST_ACK, ALU_DONE, ALU_ERR, sel_data, sel_dira, sel_dirb, sel_write,
                            DIR_EXT, BUSY}, mk(0, 0, 0, 2'd0, 0, 0, 2'd2, 5'h0b, 0));
    check("reset_state", dbg_state, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // host write
    data_in = 8'ha5;
    host_op(2'b00, 5'h12);
    check("write_bank", bank[5'h12], 8'ha5);

    // host read: no write, data visible on B in ack cycle
    wc = wr_count;
    host_op(2'b01, 5'h07);
    check("read_nowrite", wr_count, wc);
    host_op(2'b01, 5'h12);
    check("read_data", rd_capture, 8'ha5);

    // NOP acks in IDLE with no bank access
    wc = wr_count;
    host_op(2'b11, 5'h1c);
    check("nop_nowrite", wr_count, wc);

    // random host writes then read-back
    for (int n = 0; n < 4; n++) begin
      ra = ADDRW'($urandom_range(0, DEPTH - 1));
      rv = 8'($urandom_range(1, 255));
      data_in = rv;
      host_op(2'b00, ra);
      check("rand_write", bank[ra], rv);
      host_op(2'b01, ra);
      check("rand_read", rd_capture, rv);
    end

    // ALU handshake on cycle 5
    result = 8'h3c;
    alu_op(5);
    check("alu_bank", bank[ctl_a], 8'h3c);

    // ALU handshake on the very last allowed cycle
    result = 8'h5a;
    alu_op(MAX_WAIT - 1);
    check("alu_last_bank", bank[ctl_a], 8'h5a);

    // ALU timeout: no write
    wc = wr_count;
    a_before = bank[ctl_a];
    result = 8'hee;
    alu_op(-1);
    check("timeout_nowrite", wr_count, wc);
    check("timeout_bank", bank[ctl_a], a_before);

    // clear-all
    wc = wr_count;
    host_op(2'b10, 5'h01);
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (bank[i] !== 8'h00) nz++;
    check("clear_nonzero", nz, 0);
    check("clear_writes", wr_count, wc + DEPTH);

    // reset mid-clear at counter 10
    data_in = 8'h77;
    host_op(2'b00, 5'h1e);
    HOST_OP  = 2'b10;
    HOST_REQ = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 0, 2'd2, 5'h1e, 0));
    for (int i = 0; i <= 10; i++)
      exp_q.push_back(mk(0, 0, 0, 2'd2, 1, 0, 2'd3, ADDRW'(i), 1));
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 0, 2'd2, 5'h1e, 0));
    @(posedge CLK);
    #1;
    HOST_REQ = 1'b0;
    repeat (10) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drain();
    check("rst_midclr_state", dbg_state, 0);
    check("rst_midclr_keep", bank[5'h1e], 8'h77);
    host_op(2'b10, 5'h00);
    check("reclear_bank", bank[5'h1e], 8'h00);

    // contention after reset: host, ALU, host
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    data_in   = 8'h11;
    result    = 8'h22;
    HOST_OP   = 2'b00;
    HOST_ADDR = 5'h09;
    HOST_REQ  = 1'b1;
    ALU_REQ   = 1'b1;
    READY     = 1'b1;
    WRITE_REQ = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 0, 2'd2, 5'h09, 0));
    exp_q.push_back(mk(1, 0, 0, 2'd0, 1, 0, 2'd3, 5'h09, 1));
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 0, 2'd2, 5'h09, 0));
    exp_q.push_back(mk(0, 1, 0, 2'd1, 0, 0, 2'd1, 5'h09, 1));
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 0, 2'd2, 5'h09, 0));
    exp_q.push_back(mk(1, 0, 0, 2'd0, 1, 0, 2'd3, 5'h09, 1));
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 0, 2'd2, 5'h09, 0));
    repeat (6) begin
      @(posedge CLK);
      #1;
    end
    HOST_REQ  = 1'b0;
    ALU_REQ   = 1'b0;
    READY     = 1'b0;
    WRITE_REQ = 1'b0;
    drain();
    check("contend_host_bank", bank[5'h09], 8'h11);
    check("contend_alu_bank", bank[ctl_a], 8'h22);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
